// File: rtl/operand_select_pipe.sv
// Purpose : N:1 operand select with a registered, elastic valid/ready output.
// Latency : 1 cycle from accept to out_valid when the output slot is free or firing.
// Backpres: 2-entry skid (main + skid); in_ready is registered and drops once the skid slot holds a beat.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   in_data, sel        N packed WIDTH-bit inputs and the index of the one to forward
//   in_valid, in_ready  upstream handshake (in_ready = skid slot empty, from a register)
//   flush               drops every held beat and any beat accepted in the same cycle
//   out_data, out_err   registered selected word and "sel was out of range" flag
//   out_valid, out_ready downstream handshake
module operand_select_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Elaboration-time legality of the parameter set.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("operand_select_pipe: N must lie in 2..16");
    end
    if ((1 << SEL_W) < N) begin : g_bad_sel_w
        $error("operand_select_pipe: SEL_W too narrow to address N inputs");
    end

    // ------------------------------------------------------------------
    // Select. Out-of-range indices produce an all-zero word with err set,
    // matching the zero default of the older fixed-size selectors.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sel_dat;
    logic             w_sel_err;

    always_comb begin
        w_sel_dat = '0;
        w_sel_err = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_dat = in_data[k*WIDTH +: WIDTH];
                w_sel_err = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: main slot drives the outputs, skid slot absorbs the one
    // beat that can be accepted while the main slot is stalled.
    // ------------------------------------------------------------------
    logic             r_main_vld;
    logic [WIDTH-1:0] r_main_dat;
    logic             r_main_err;
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_skid_dat;
    logic             r_skid_err;

    logic             w_accept;
    logic             w_fire;

    // in_ready depends only on r_skid_vld, so there is no combinational
    // path from in_valid or out_ready back to the upstream stage.
    assign in_ready  = ~r_skid_vld;
    assign w_accept  = in_valid & ~r_skid_vld;
    assign w_fire    = r_main_vld & out_ready;

    assign out_valid = r_main_vld;
    assign out_data  = r_main_dat;
    assign out_err   = r_main_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_vld <= 1'b0;
            r_main_dat <= '0;
            r_main_err <= 1'b0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
            r_skid_err <= 1'b0;
        end else if (flush) begin
            // Data registers keep their contents; they are masked by out_valid = 0.
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_main_vld || w_fire) begin
            // Main slot is free this edge. The skid beat is older than any
            // new beat, so it goes first to keep acceptance order. While the
            // skid slot is full in_ready is low, so no beat is lost here.
            if (r_skid_vld) begin
                r_main_vld <= 1'b1;
                r_main_dat <= r_skid_dat;
                r_main_err <= r_skid_err;
                r_skid_vld <= 1'b0;
            end else if (w_accept) begin
                r_main_vld <= 1'b1;
                r_main_dat <= w_sel_dat;
                r_main_err <= w_sel_err;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (w_accept) begin
            // Main slot stalled: park the new beat in the skid slot.
            r_skid_vld <= 1'b1;
            r_skid_dat <= w_sel_dat;
            r_skid_err <= w_sel_err;
        end
    end

endmodule
